// File: rtl/interrupt_controller_if.sv
// CPU-side bus bundle for interrupt_controller: IACK decode inputs and the IPL and
// bus-termination outputs. The CPU (or a bench) uses master; the controller uses slave.
interface interrupt_controller_if;
    logic       cpu_as_n;
    logic [2:0] cpu_fc;
    logic [3:0] cpu_a_hi;
    logic [2:0] cpu_a_lvl;
    logic [2:0] ipl_n;
    logic       vpa_n;
    logic       dtack_n;
    logic       berr_n;
    logic       vec_oe;
    logic [7:0] vec;

    modport master (
        output cpu_as_n, cpu_fc, cpu_a_hi, cpu_a_lvl,
        input  ipl_n, vpa_n, dtack_n, berr_n, vec_oe, vec
    );

    modport slave (
        input  cpu_as_n, cpu_fc, cpu_a_hi, cpu_a_lvl,
        output ipl_n, vpa_n, dtack_n, berr_n, vec_oe, vec
    );
endinterface

// File: rtl/interrupt_controller.sv
// 68000 interrupt controller: synchronizes/latches seven IRQ lines, drives encoded IPL and
// terminates IACK cycles. Define INTCTRL_VECTOR_EN for vectored (DTACK + vector) responses.
module interrupt_controller #(
    parameter logic [6:0] EDGE_MASK   = 7'b1000000,
    parameter logic [7:0] VECTOR_BASE = 8'h40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             irq_n,
    input  logic [6:0]             irq_en,
    interrupt_controller_if.slave  bus
);

`ifdef INTCTRL_VECTOR_EN
    localparam logic VEC_MODE = 1'b1;
`else
    localparam logic VEC_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_SPUR = 2'd2
    } state_t;

    state_t     r_state;
    logic [6:0] r_irq_m;
    logic [6:0] r_s_irq;
    logic [6:0] r_s_irq_d;
    logic       r_as_m;
    logic       r_s_as;
    logic       r_s_as_d;
    logic [6:0] r_pend;
    logic [2:0] r_ipl_n;
    logic       r_vpa_n;
    logic       r_dtack_n;
    logic       r_berr_n;
    logic       r_vec_oe;
    logic [7:0] r_vec;

    logic [6:0] w_act;
    logic [7:0] w_act_ext;
    logic [7:0] w_lvl_dec;
    logic       w_iack;
    logic       w_hit;
    logic       w_take;
    logic [6:0] w_set;
    logic [6:0] w_clr;
    logic [7:0] w_vec;

    // Highest active level wins; encoded active-low, 3'b111 when nothing is active.
    function automatic logic [2:0] f_encode(input logic [6:0] a);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (a[i]) lvl = 3'(i + 1);
        end
        return ~lvl;
    endfunction

    assign w_act     = r_pend & irq_en;
    assign w_act_ext = {w_act, 1'b0};
    assign w_lvl_dec = 8'b1 << bus.cpu_a_lvl;
    assign w_iack    = r_s_as_d && !r_s_as && (bus.cpu_fc == 3'b111) && (bus.cpu_a_hi == 4'hF);
    assign w_hit     = w_act_ext[bus.cpu_a_lvl];
    assign w_take    = (r_state == ST_IDLE) && w_iack && w_hit;
    assign w_set     = r_s_irq_d & ~r_s_irq & EDGE_MASK;
    assign w_clr     = w_take ? (w_lvl_dec[7:1] & EDGE_MASK) : 7'b0;
    assign w_vec     = VECTOR_BASE + {5'b0, bus.cpu_a_lvl};

    // Synchronizers, pending latch and IPL encoder
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_m   <= 7'h7F;
            r_s_irq   <= 7'h7F;
            r_s_irq_d <= 7'h7F;
            r_as_m    <= 1'b1;
            r_s_as    <= 1'b1;
            r_s_as_d  <= 1'b1;
            r_pend    <= 7'b0;
            r_ipl_n   <= 3'b111;
        end else begin
            r_irq_m   <= irq_n;
            r_s_irq   <= r_irq_m;
            r_s_irq_d <= r_s_irq;
            r_as_m    <= bus.cpu_as_n;
            r_s_as    <= r_as_m;
            r_s_as_d  <= r_s_as;
            // Set is ORed after the clear so a new edge in the acknowledge cycle survives.
            r_pend    <= (~r_s_irq & ~EDGE_MASK)
                       | (((r_pend & ~w_clr) | w_set) & EDGE_MASK);
            r_ipl_n   <= f_encode(w_act);
        end
    end

    // IACK response FSM with registered bus-termination outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_vpa_n   <= 1'b1;
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
            r_vec_oe  <= 1'b0;
            r_vec     <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_iack) begin
                        if (w_hit) begin
                            r_state   <= ST_RESP;
                            r_vpa_n   <= VEC_MODE;
                            r_dtack_n <= ~VEC_MODE;
                            r_vec_oe  <= VEC_MODE;
                            r_vec     <= VEC_MODE ? w_vec : 8'h00;
                        end else begin
                            r_state  <= ST_SPUR;
                            r_berr_n <= 1'b0;
                        end
                    end
                end
                ST_RESP, ST_SPUR: begin
                    if (r_s_as) begin
                        r_state   <= ST_IDLE;
                        r_vpa_n   <= 1'b1;
                        r_dtack_n <= 1'b1;
                        r_berr_n  <= 1'b1;
                        r_vec_oe  <= 1'b0;
                        r_vec     <= 8'h00;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ipl_n   = r_ipl_n;
    assign bus.vpa_n   = r_vpa_n;
    assign bus.dtack_n = r_dtack_n;
    assign bus.berr_n  = r_berr_n;
    assign bus.vec_oe  = r_vec_oe;
    assign bus.vec     = r_vec;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with source 2 (level 3) edge-typed; expectations
// follow INTCTRL_VECTOR_EN so the same bench covers both response modes.
module tb_interrupt_controller;

    logic       clk;
    logic       reset;
    logic [6:0] irq_n;
    logic [6:0] irq_en;
    int         n_checks;
    int         n_pass;

    interrupt_controller_if u_bus ();

    interrupt_controller #(
        .EDGE_MASK   (7'b0000100),
        .VECTOR_BASE (8'h40)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .irq_n  (irq_n),
        .irq_en (irq_en),
        .bus    (u_bus)
    );

    // Response word: {vpa_n, dtack_n, berr_n, vec_oe, vec}
    logic [11:0] obs;
    assign obs = {u_bus.vpa_n, u_bus.dtack_n, u_bus.berr_n, u_bus.vec_oe, u_bus.vec};

    localparam logic [11:0] R_IDLE = {1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    localparam logic [11:0] R_SPUR = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
`ifdef INTCTRL_VECTOR_EN
    localparam logic [11:0] R_ACK3 = {1'b1, 1'b0, 1'b1, 1'b1, 8'h43};
    localparam logic [11:0] R_ACK4 = {1'b1, 1'b0, 1'b1, 1'b1, 8'h44};
`else
    localparam logic [11:0] R_ACK3 = {1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    localparam logic [11:0] R_ACK4 = {1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        irq_n           = 7'h7F;
        irq_en          = 7'h7F;
        u_bus.cpu_as_n  = 1'b1;
        u_bus.cpu_fc    = 3'b000;
        u_bus.cpu_a_hi  = 4'h0;
        u_bus.cpu_a_lvl = 3'd0;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic as_assert(input logic [2:0] fc, input logic [2:0] lvl);
        u_bus.cpu_fc    = fc;
        u_bus.cpu_a_hi  = 4'hF;
        u_bus.cpu_a_lvl = lvl;
        u_bus.cpu_as_n  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (u_bus.ipl_n !== 3'b111) $display("FAIL reset_ipl[%0d]: got %b want 111", i, u_bus.ipl_n);
            else n_pass++;
            n_checks++;
            if (obs !== R_IDLE) $display("FAIL reset_resp[%0d]: got %h want %h", i, obs, R_IDLE);
            else n_pass++;
            tick(1);
        end
    endtask

    task automatic test_level();
        do_reset();
        irq_n = 7'b1011011;
        tick(3);
        n_checks++;
        if (u_bus.ipl_n !== 3'b111) $display("FAIL level_early: got %b want 111", u_bus.ipl_n);
        else n_pass++;
        tick(1);
        n_checks++;
        if (u_bus.ipl_n !== 3'b001) $display("FAIL level_both: got %b want 001", u_bus.ipl_n);
        else n_pass++;
        irq_n = 7'b1111011;
        tick(3);
        n_checks++;
        if (u_bus.ipl_n !== 3'b001) $display("FAIL level_rel_early: got %b want 001", u_bus.ipl_n);
        else n_pass++;
        tick(1);
        n_checks++;
        if (u_bus.ipl_n !== 3'b100) $display("FAIL level_rel: got %b want 100", u_bus.ipl_n);
        else n_pass++;
    endtask

    task automatic test_edge_iack();
        do_reset();
        irq_n[2] = 1'b0;
        tick(1);
        irq_n[2] = 1'b1;
        tick(4);
        n_checks++;
        if (u_bus.ipl_n !== 3'b100) $display("FAIL edge_latched: got %b want 100", u_bus.ipl_n);
        else n_pass++;
        as_assert(3'b111, 3'd3);
        tick(2);
        n_checks++;
        if (obs !== R_IDLE) $display("FAIL edge_iack_e2: got %h want %h", obs, R_IDLE);
        else n_pass++;
        tick(1);
        n_checks++;
        if (obs !== R_ACK3) $display("FAIL edge_iack_e3: got %h want %h", obs, R_ACK3);
        else n_pass++;
        tick(1);
        n_checks++;
        if (u_bus.ipl_n !== 3'b111) $display("FAIL edge_cleared_ipl: got %b want 111", u_bus.ipl_n);
        else n_pass++;
        tick(2);
        n_checks++;
        if (obs !== R_ACK3) $display("FAIL edge_iack_hold: got %h want %h", obs, R_ACK3);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        tick(2);
        n_checks++;
        if (obs !== R_ACK3) $display("FAIL edge_rel_e2: got %h want %h", obs, R_ACK3);
        else n_pass++;
        tick(1);
        n_checks++;
        if (obs !== R_IDLE) $display("FAIL edge_rel_e3: got %h want %h", obs, R_IDLE);
        else n_pass++;
        n_checks++;
        if (u_bus.ipl_n !== 3'b111) $display("FAIL edge_after_ipl: got %b want 111", u_bus.ipl_n);
        else n_pass++;
    endtask

    task automatic test_spurious();
        do_reset();
        as_assert(3'b111, 3'd4);
        tick(3);
        n_checks++;
        if (obs !== R_SPUR) $display("FAIL spur_none: got %h want %h", obs, R_SPUR);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        tick(3);
        n_checks++;
        if (obs !== R_IDLE) $display("FAIL spur_rel: got %h want %h", obs, R_IDLE);
        else n_pass++;
        irq_n[3] = 1'b0;
        tick(4);
        n_checks++;
        if (u_bus.ipl_n !== 3'b011) $display("FAIL lvl4_ipl: got %b want 011", u_bus.ipl_n);
        else n_pass++;
        irq_en = 7'b1110111;
        tick(1);
        n_checks++;
        if (u_bus.ipl_n !== 3'b111) $display("FAIL masked_ipl: got %b want 111", u_bus.ipl_n);
        else n_pass++;
        as_assert(3'b111, 3'd4);
        tick(3);
        n_checks++;
        if (obs !== R_SPUR) $display("FAIL spur_masked: got %h want %h", obs, R_SPUR);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        irq_en = 7'h7F;
        tick(3);
        n_checks++;
        if (u_bus.ipl_n !== 3'b011) $display("FAIL unmasked_ipl: got %b want 011", u_bus.ipl_n);
        else n_pass++;
        as_assert(3'b111, 3'd4);
        tick(3);
        n_checks++;
        if (obs !== R_ACK4) $display("FAIL lvl4_ack: got %h want %h", obs, R_ACK4);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        tick(3);
        n_checks++;
        if (u_bus.ipl_n !== 3'b011) $display("FAIL lvl4_still_pend: got %b want 011", u_bus.ipl_n);
        else n_pass++;
        as_assert(3'b101, 3'd4);
        tick(3);
        n_checks++;
        if (obs !== R_IDLE) $display("FAIL non_iack_ignored: got %h want %h", obs, R_IDLE);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        irq_n[3] = 1'b1;
        tick(3);
        as_assert(3'b111, 3'd0);
        tick(3);
        n_checks++;
        if (obs !== R_SPUR) $display("FAIL spur_lvl0: got %h want %h", obs, R_SPUR);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        tick(3);
    endtask

    task automatic test_set_clear();
        do_reset();
        irq_n[2] = 1'b0;
        tick(1);
        irq_n[2] = 1'b1;
        tick(5);
        irq_n[2] = 1'b0;
        as_assert(3'b111, 3'd3);
        tick(3);
        n_checks++;
        if (obs !== R_ACK3) $display("FAIL setclr_ack: got %h want %h", obs, R_ACK3);
        else n_pass++;
        irq_n[2] = 1'b1;
        u_bus.cpu_as_n = 1'b1;
        tick(3);
        n_checks++;
        if (obs !== R_IDLE) $display("FAIL setclr_rel: got %h want %h", obs, R_IDLE);
        else n_pass++;
        tick(1);
        n_checks++;
        if (u_bus.ipl_n !== 3'b100) $display("FAIL setclr_ipl: got %b want 100", u_bus.ipl_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        irq_n[2] = 1'b0;
        tick(1);
        irq_n[2] = 1'b1;
        tick(4);
        as_assert(3'b111, 3'd3);
        tick(3);
        n_checks++;
        if (obs !== R_ACK3) $display("FAIL mid_ack: got %h want %h", obs, R_ACK3);
        else n_pass++;
        reset = 1'b1;
        u_bus.cpu_as_n = 1'b1;
        tick(1);
        n_checks++;
        if (obs !== R_IDLE) $display("FAIL mid_reset_resp: got %h want %h", obs, R_IDLE);
        else n_pass++;
        n_checks++;
        if (u_bus.ipl_n !== 3'b111) $display("FAIL mid_reset_ipl: got %b want 111", u_bus.ipl_n);
        else n_pass++;
        tick(1);
        reset = 1'b0;
        tick(2);
        as_assert(3'b111, 3'd3);
        tick(3);
        n_checks++;
        if (obs !== R_SPUR) $display("FAIL post_reset_spur: got %h want %h", obs, R_SPUR);
        else n_pass++;
        u_bus.cpu_as_n = 1'b1;
        tick(3);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_level();
        test_edge_iack();
        test_spurious();
        test_set_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt controller for the 68000 glue logic. It samples seven active-low interrupt request lines, latches edge-type sources, masks them, and drives the priority-encoded IPL to the CPU. It also decodes the CPU interrupt-acknowledge (IACK) cycle and terminates it with autovector, vector or bus error. It sits between the board interrupt sources and the CPU bus-control pins, in front of the priority encoder function, which it absorbs.

## Interface
- EDGE_MASK, 7'b1000000: per-source type. Bit i=1 means source i (IRQ level i+1) is edge-triggered (falling edge latched); 0 means level-sensitive.
- VECTOR_BASE, 8'h40: base of the vectored response; used only when vectored mode is compiled in.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_n  in  7  asynchronous active-low requests; bit i = level i+1.
- irq_en  in  7  synchronous per-source enable; 0 masks the source from ipl_n and IACK matching.
- cpu_as_n  in  1  CPU address strobe, asynchronous.
- cpu_fc  in  3  CPU function code; sampled only while synchronized AS is low.
- cpu_a_hi  in  4  CPU A19:16.
- cpu_a_lvl  in  3  CPU A3:1, the acknowledged level.
- ipl_n  out  3  registered encoded interrupt level to CPU; 3'b111 = none, 3'b000 = level 7.
- vpa_n  out  1  autovector request, active low.
- dtack_n  out  1  vector-cycle acknowledge, active low.
- berr_n  out  1  bus error for a spurious IACK, active low.
- vec_oe  out  1  high while vec must be driven onto D7:0.
- vec  out  8  interrupt vector number.

## Operation
- Synchronizers: irq_n and cpu_as_n each pass through a 2-flop synchronizer. s_irq and s_as are the synchronizer outputs; both reset to all-ones.
- Pending register pend[6:0], reset 0, updated every cycle:
  - Level-type sources: pend[i] <= ~s_irq[i].
  - Edge-type sources: set when the previous s_irq[i] is 1 and the current one is 0.
  - Edge-type sources: clear when an IACK is accepted for level i+1.
  - Set and clear in the same cycle: set wins.
- Active set act = pend & irq_en. ipl_n <= priority encode of act, highest level wins, 3'b111 if empty.
- IACK decode: a falling s_as (previous 1, current 0) with cpu_fc=3'b111 and cpu_a_hi=4'hF. L = cpu_a_lvl.
- A falling s_as that does not decode as IACK is ignored.
- FSM states and transitions:
  - IDLE: on IACK decode, go to RESP if L≠0 and act[L-1]=1. Otherwise go to SPUR.
  - RESP: response outputs asserted. Go to IDLE on the first cycle s_as=1.
  - SPUR: berr_n=0. Go to IDLE on the first cycle s_as=1.
- Edge-type pend[L-1] clears on the IDLE→RESP transition. A level-type source stays pending until its line releases.
- Only one response per AS assertion. A new IACK is recognized only after returning to IDLE and seeing s_as high.
- Outputs are registered, decoded from the FSM state. Inactive values: vpa_n=1, dtack_n=1, berr_n=1, vec_oe=0, vec=8'h00.
- Reset at any time, including mid-IACK: FSM to IDLE and pend cleared. All outputs take their inactive values, with ipl_n=3'b111, on the edge where reset is sampled high.

## Timing
- An irq_n transition is visible in s_irq after 2 edges, in pend after 3, and on ipl_n after 4.
- IACK: the falling cpu_as_n edge appears in s_as after 2 edges. The FSM enters RESP/SPUR on edge 3, and the response outputs are valid from that same edge.
- Release: cpu_as_n rising appears in s_as after 2 edges. All response outputs deassert on edge 3.
- Masking: a change of irq_en affects ipl_n 1 edge later and IACK matching immediately.
- vec arithmetic: VECTOR_BASE + L, 8 bits, wraps modulo 256.

## Configuration
- Macro INTCTRL_VECTOR_EN.
- Defined (vectored mode): in RESP, dtack_n=0, vec_oe=1, vec=VECTOR_BASE+L, vpa_n=1.
- Undefined (autovector mode): in RESP, vpa_n=0, dtack_n=1, vec_oe=0, vec=8'h00. VECTOR_BASE is unused.
- SPUR behaviour is identical in both modes.

## Test plan
- Reset, then all irq_n high: ipl_n=3'b111. vpa_n, dtack_n and berr_n are 1 and vec_oe=0 continuously.
- irq_n[2] and irq_n[5] low together (level-type): ipl_n=3'b001 on the 4th edge. Release irq_n[5]: ipl_n=3'b100.
- With EDGE_MASK=7'b0000100, pulse irq_n[2] low for 1 cycle, then run IACK with cpu_a_lvl=3:
  - Autovector mode: vpa_n=0 from edge 3 until AS release plus 3 edges; pend[2] then reads 0 and ipl_n=3'b111.
  - Vectored mode: dtack_n=0 and vec=8'h43 over the same window.
- IACK at level 4 with no source pending, or with irq_en[3]=0: berr_n=0; vpa_n and dtack_n stay 1.
- New falling edge on an edge-type source in the same cycle its IACK clears it: pend stays 1 and ipl_n is still asserted after the IACK completes.
- Assert reset while in RESP: all outputs inactive on that edge. A following IACK without pending sources yields SPUR.
